// File: rtl/maj_eval_pkg.sv
// Shared types and helpers for the time-multiplexed majority-gate evaluator.
package maj_eval_pkg;

  localparam int unsigned GATE_IDX_W = 5;
  localparam int unsigned IDX_CONST0 = 0;
  localparam int unsigned IDX_X_BASE = 1;
  localparam int unsigned IDX_G_BASE = 8;

  // One gate instruction: three operand indices, each with an inversion bit
  typedef struct packed {
    logic                  inv_a;
    logic [GATE_IDX_W-1:0] idx_a;
    logic                  inv_b;
    logic [GATE_IDX_W-1:0] idx_b;
    logic                  inv_c;
    logic [GATE_IDX_W-1:0] idx_c;
  } gate_instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    CAPT = 2'd2
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/maj_operand_mux.sv
// Selects one operand bit from {constant 0, primary inputs, node file} and applies inversion.
module maj_operand_mux
  import maj_eval_pkg::*;
#(
  parameter int unsigned NUM_IN    = 7,
  parameter int unsigned MAX_GATES = 16,
  parameter int unsigned IDX_W     = 5
) (
  input  logic [IDX_W-1:0]     idx,
  input  logic                 inv,
  input  logic [NUM_IN-1:0]    x,
  input  logic [MAX_GATES-1:0] nodes,
  output logic                 val_c
);

  localparam int unsigned XSEL_W  = $clog2(NUM_IN);
  localparam int unsigned NSEL_W  = $clog2(MAX_GATES);
  localparam int unsigned IDX_END = IDX_G_BASE + MAX_GATES;

  logic raw;

  // Indices past the node file read as 0
  always_comb begin
    raw = 1'b0;
    if (idx == IDX_W'(IDX_CONST0)) begin
      raw = 1'b0;
    end else if (idx < IDX_W'(IDX_G_BASE)) begin
      raw = x[XSEL_W'(idx - IDX_W'(IDX_X_BASE))];
    end else if (idx < IDX_W'(IDX_END)) begin
      raw = nodes[NSEL_W'(idx - IDX_W'(IDX_G_BASE))];
    end
  end

  assign val_c = raw ^ inv;

endmodule

// File: rtl/maj_seq_eval.sv
// Executes a programmable MAJ3 gate list one gate per cycle, for one vector or a full truth-table sweep.
module maj_seq_eval
  import maj_eval_pkg::*;
#(
  parameter int unsigned NUM_IN    = 7,
  parameter int unsigned MAX_GATES = 16,
  parameter int unsigned IDX_W     = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         prog_we,
  input  logic [$clog2(MAX_GATES)-1:0] prog_addr,
  input  logic [3*(IDX_W+1)-1:0]       prog_data,
  input  logic [IDX_W-1:0]             num_gates,
  input  logic [IDX_W-1:0]             out_sel,
  input  logic                         sweep,
  input  logic [NUM_IN-1:0]            x,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         result,
  output logic [(2**NUM_IN)-1:0]       tt
);

  localparam int unsigned PC_W = $clog2(MAX_GATES);

  state_t                 state, state_nx;
  gate_instr_t            prog_ram [MAX_GATES];
  gate_instr_t            instr;
  logic [PC_W-1:0]        pc;
  logic [NUM_IN-1:0]      vec;
  logic [IDX_W-1:0]       ng_q, out_sel_q, ng_sat_c, sel_a;
  logic                   sweep_q;
  logic [MAX_GATES-1:0]   nodes;
  logic                   inv_a_sel;
  logic                   opa, opb, opc;
  logic                   load_c, eval_c, capt_c, next_vec_c;
  logic                   last_gate_c, last_vec_c;

  assign instr       = prog_ram[pc];
  assign ng_sat_c    = (num_gates > IDX_W'(MAX_GATES)) ? IDX_W'(MAX_GATES) : num_gates;
  assign last_gate_c = (IDX_W'(pc) == (ng_q - IDX_W'(1)));
  assign last_vec_c  = &vec;

  // Operand A doubles as the out_sel reader during capture
  assign sel_a     = capt_c ? out_sel_q : instr.idx_a;
  assign inv_a_sel = capt_c ? 1'b0 : instr.inv_a;

  maj_operand_mux #(.NUM_IN(NUM_IN), .MAX_GATES(MAX_GATES), .IDX_W(IDX_W)) u_mux_a (
    .idx(sel_a), .inv(inv_a_sel), .x(vec), .nodes(nodes), .val_c(opa)
  );
  maj_operand_mux #(.NUM_IN(NUM_IN), .MAX_GATES(MAX_GATES), .IDX_W(IDX_W)) u_mux_b (
    .idx(instr.idx_b), .inv(instr.inv_b), .x(vec), .nodes(nodes), .val_c(opb)
  );
  maj_operand_mux #(.NUM_IN(NUM_IN), .MAX_GATES(MAX_GATES), .IDX_W(IDX_W)) u_mux_c (
    .idx(instr.idx_c), .inv(instr.inv_c), .x(vec), .nodes(nodes), .val_c(opc)
  );

  // Program RAM: writable only while idle, contents not reset
  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE) begin
      prog_ram[prog_addr] <= gate_instr_t'(prog_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (load_c) state_nx = (ng_sat_c == '0) ? CAPT : EVAL;
      EVAL: if (last_gate_c) state_nx = CAPT;
      CAPT: begin
        if (next_vec_c) state_nx = (ng_q == '0) ? CAPT : EVAL;
        else            state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A start during the done cycle is dropped so back-to-back runs are spaced by one idle cycle
  always_comb begin
    load_c     = 1'b0;
    eval_c     = 1'b0;
    capt_c     = 1'b0;
    next_vec_c = 1'b0;
    unique case (state)
      IDLE: load_c = start && !done;
      EVAL: eval_c = 1'b1;
      CAPT: begin
        capt_c     = 1'b1;
        next_vec_c = sweep_q && !last_vec_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 1'b0;
      tt        <= '0;
      nodes     <= '0;
      pc        <= '0;
      vec       <= '0;
      ng_q      <= '0;
      out_sel_q <= '0;
      sweep_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load_c) begin
        ng_q      <= ng_sat_c;
        out_sel_q <= out_sel;
        sweep_q   <= sweep;
        vec       <= sweep ? '0 : x;
        pc        <= '0;
        nodes     <= '0;
        busy      <= 1'b1;
      end
      if (eval_c) begin
        nodes[pc] <= maj3(opa, opb, opc);
        pc        <= pc + PC_W'(1);
      end
      if (capt_c) begin
        result   <= opa;
        tt[vec]  <= opa;
        pc       <= '0;
        if (next_vec_c) begin
          vec   <= vec + NUM_IN'(1);
          nodes <= '0;
        end else begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maj_seq_eval.sv
// Directed and randomized checks of maj_seq_eval against a gate-list reference model.
module tb_maj_seq_eval;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         prog_we;
  logic [3:0]   prog_addr;
  logic [17:0]  prog_data;
  logic [4:0]   num_gates;
  logic [4:0]   out_sel;
  logic         sweep;
  logic [6:0]   x;
  logic         start;
  logic         busy, done, result;
  logic [127:0] tt;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [17:0]  tb_prog [16];
  logic [127:0] model_tt;

  maj_seq_eval dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .num_gates(num_gates), .out_sel(out_sel),
    .sweep(sweep), .x(x), .start(start), .busy(busy), .done(done),
    .result(result), .tt(tt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] g3(input bit ia, input int a, input bit ib, input int b,
                                     input bit ic, input int c);
    return {ia, 5'(a), ib, 5'(b), ic, 5'(c)};
  endfunction

  // Reference: index 0 const, 1..7 inputs, 8..23 nodes, otherwise 0
  function automatic bit ref_opnd(input int idx, input logic [15:0] nd, input int xv);
    if (idx >= 1 && idx <= 7) return ((xv >> (idx - 1)) & 1) != 0;
    if (idx >= 8 && idx < 24) return nd[idx-8];
    return 1'b0;
  endfunction

  function automatic bit ref_eval(input int ng, input int os, input int xv);
    logic [15:0] nd;
    logic [5:0]  f;
    int          n, s;
    nd = '0;
    n  = (ng > 16) ? 16 : ng;
    for (int k = 0; k < n; k++) begin
      s = 0;
      for (int op = 0; op < 3; op++) begin
        f = 6'(tb_prog[k] >> (12 - 6 * op));
        s += int'(ref_opnd(int'(f[4:0]), nd, xv) ^ f[5]);
      end
      nd[k] = (s >= 2);
    end
    return ref_opnd(os, nd, xv);
  endfunction

  task automatic prog(input int a, input logic [17:0] d);
    prog_we = 1'b1; prog_addr = 4'(a); prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    tb_prog[a] = d;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Start a run (optionally with a coincident program write), check latency/result/tt,
  // then offer a start in the done cycle, which must be ignored.
  task automatic run(input bit sw, input int xv, input int ng, input int os, input string tag,
                     input bit wr = 1'b0, input int wa = 0, input logic [17:0] wd = '0);
    int cyc, n, exp_lat;
    sweep = sw; x = 7'(xv); num_gates = 5'(ng); out_sel = 5'(os); start = 1'b1;
    if (wr) begin
      prog_we = 1'b1; prog_addr = 4'(wa); prog_data = wd;
      tb_prog[wa] = wd;
    end
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0;
    wait_done(cyc);
    n = (ng > 16) ? 16 : ng;
    if (sw) for (int v = 0; v < 128; v++) model_tt[v] = ref_eval(ng, os, v);
    else    model_tt[xv] = ref_eval(ng, os, xv);
    exp_lat = sw ? 128 * (n + 1) : n + 1;
    check({tag, " latency"}, 128'(cyc), 128'(exp_lat));
    check({tag, " result"}, 128'(result), 128'(sw ? model_tt[127] : model_tt[xv]));
    check({tag, " tt"}, tt, model_tt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " start in done cycle"}, 128'(busy), 128'(0));
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    num_gates = '0; out_sel = '0; sweep = 1'b0; x = '0; start = 1'b0;
    model_tt = '0;
    for (int i = 0; i < 16; i++) tb_prog[i] = '0;
    repeat (2) @(posedge clk); #1;
    check("reset busy", 128'(busy), 128'(0));
    check("reset done", 128'(done), 128'(0));
    check("reset result", 128'(result), 128'(0));
    check("reset tt", tt, 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // g0 = MAJ(x0,x1,x2), full sweep
    prog(0, g3(0, 1, 0, 2, 0, 3));
    run(1, 0, 1, 8, "sweep maj3");
    check("sweep maj3 tt const", tt, {16{8'hE8}});

    // g0 = MAJ(~const0,x0,x1) = x0|x1
    prog(0, g3(1, 0, 0, 1, 0, 2));
    run(1, 0, 1, 8, "sweep or2");
    check("sweep or2 tt const", tt, {32{4'hE}});

    // Five-gate network, single vectors
    prog(0, g3(0, 1, 0, 4, 0, 5));
    prog(1, g3(0, 4, 0, 7, 0, 8));
    prog(2, g3(0, 2, 0, 3, 0, 8));
    prog(3, g3(0, 6, 0, 9, 0, 10));
    prog(4, g3(0, 1, 0, 10, 0, 11));
    run(0, 7'h07, 5, 12, "net5 x07"); check("net5 x07 const", 128'(result), 128'(1));
    run(0, 7'h19, 5, 12, "net5 x19"); check("net5 x19 const", 128'(result), 128'(0));
    run(0, 7'h7F, 5, 12, "net5 x7f"); check("net5 x7f const", 128'(result), 128'(1));
    run(0, 7'h00, 5, 12, "net5 x00"); check("net5 x00 const", 128'(result), 128'(0));

    // Zero gates reads an input directly
    run(0, 7'h04, 0, 3, "zero gates"); check("zero gates const", 128'(result), 128'(1));

    // Forward reference reads 0
    prog(0, g3(0, 9, 0, 1, 0, 2));
    run(0, 7'h01, 1, 8, "forward ref"); check("forward ref const", 128'(result), 128'(0));

    // start and prog_we while busy are ignored
    prog(0, g3(1, 0, 0, 1, 0, 2));
    sweep = 1'b1; num_gates = 5'd1; out_sel = 5'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = g3(0, 3, 0, 4, 0, 5);
    start = 1'b1; sweep = 1'b0; x = 7'h01; num_gates = 5'd0;
    @(posedge clk); #1;
    prog_we = 1'b0; start = 1'b0;
    wait_done(cyc);
    check("busy ignore latency", 128'(cyc + 11), 128'(256));
    check("busy ignore tt", tt, {32{4'hE}});
    for (int v = 0; v < 128; v++) model_tt[v] = ref_eval(1, 8, v);
    @(posedge clk); #1;
    run(0, 7'h01, 1, 8, "program kept");

    // num_gates above capacity saturates
    for (int i = 0; i < 16; i++)
      prog(i, g3(1'($urandom), $urandom_range(0, 26), 1'($urandom), $urandom_range(0, 26),
                 1'($urandom), $urandom_range(0, 26)));
    run(0, int'(7'($urandom)), 31, 23, "sat 31");
    run(0, int'(7'($urandom)), 17, 22, "sat 17");

    // Write coinciding with an accepted start is used by that run
    run(0, 7'h05, 1, 8, "coincident write", 1'b1, 0, g3(0, 1, 0, 3, 0, 4));
    check("coincident write const", 128'(result), 128'(1));

    // Randomized programs and configurations
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 16; i++)
        prog(i, g3(1'($urandom), $urandom_range(0, 26), 1'($urandom), $urandom_range(0, 26),
                   1'($urandom), $urandom_range(0, 26)));
      run((it % 4) == 3, int'(7'($urandom)), $urandom_range(0, 20), $urandom_range(0, 26),
          $sformatf("random %0d", it));
    end

    // Asynchronous reset in the middle of a sweep
    sweep = 1'b1; num_gates = 5'd2; out_sel = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset busy", 128'(busy), 128'(0));
    check("midreset done", 128'(done), 128'(0));
    check("midreset tt", tt, 128'(0));
    check("midreset result", 128'(result), 128'(0));
    model_tt = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, int'(7'($urandom)), 16, 20, "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maj_seq_eval.md
# maj_seq_eval

Time-multiplexed evaluator for 7-input majority-gate networks. A small programmable gate list (MAJ3 with per-operand inversion) is executed one gate per cycle on a single shared MAJ3 unit. It either evaluates one input vector or sweeps all 128 vectors to build the full truth table. It sits beside the combinational classification netlists as the generic engine that produces and checks their truth tables.

## Interface
Parameters:
- NUM_IN, 7, number of primary inputs (fixed at 7 for this block)
- MAX_GATES, 16, capacity of the gate program
- IDX_W, 5, operand index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- prog_we  in  1  program write strobe; ignored while busy
- prog_addr  in  4  gate slot written
- prog_data  in  18  {inv_a, idx_a, inv_b, idx_b, inv_c, idx_c}, each idx 5 bits
- num_gates  in  5  gates to execute; sampled at start; values above MAX_GATES saturate to MAX_GATES
- out_sel  in  5  operand index driven to the result; sampled at start
- sweep  in  1  0 = single vector, 1 = all 128 vectors; sampled at start
- x  in  7  input vector for single mode; x[0] is the LSB; sampled at start
- start  in  1  one-cycle start pulse; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the run completes
- result  out  1  value of out_sel for the last evaluated vector
- tt  out  128  truth table; bit v is the result for vector v

## Operation
- Operand index space:
  - 0 = constant 0
  - 1..7 = x0..x6
  - 8..8+MAX_GATES-1 = gate nodes g0..g15
  - larger indices read 0
- Each operand is XORed with its inv bit. The gate computes MAJ(a,b,c) = ab|ac|bc.
- Program RAM: MAX_GATES x 18 flops, written synchronously. Contents are undefined after reset, so software loads them before use.
- Node file: MAX_GATES bits, cleared to 0 at the start of every vector. A forward or self reference (gate k reading g_j with j≥k) reads 0.
- State machine:
  - IDLE: on start, latch the config, set vec to x (single) or 0 (sweep), set pc=0, clear the node file. Go to EVAL, or to CAPT if num_gates=0.
  - EVAL: evaluate gate pc, write node[pc], increment pc. When pc=num_gates-1, go to CAPT.
  - CAPT: read out_sel, write result and tt[vec]. In sweep mode with vec≠127: vec+1, pc=0, clear nodes, go to EVAL. Otherwise pulse done and go to IDLE.
- Single mode writes only tt[vec]; the other tt bits hold their previous values. Sweep mode overwrites all 128 bits.
- Reset (asynchronous, mid-run allowed): state=IDLE, busy=0, done=0, result=0, tt=0, node file=0, pc=0, vec=0. An interrupted run leaves no partial handshake.

## Timing
- Single-vector latency: start at cycle 0 gives done at cycle num_gates+1. result and tt are valid in the same cycle as done.
- Sweep latency: 128·(num_gates+1) cycles from start to done.
- busy falls in the cycle done is asserted. A start in that same cycle is ignored; a start in the next cycle is accepted.
- Back-to-back starts therefore occur at most once every num_gates+2 cycles.
- A prog_we coinciding with an accepted start writes the program, but the run begins in EVAL the next cycle, so the new data is used.

## Structure
- Package maj_eval_pkg holds:
  - gate_instr_t, the packed 18-bit instruction struct
  - IDX_CONST0=0, IDX_X_BASE=1, IDX_G_BASE=8
  - the state enum {IDLE, EVAL, CAPT}
  - the MAJ3 function
- One sub-module, maj_operand_mux: index plus inv bit in, operand bit out, over {const, x, node file}. It is instantiated three times.
- The program RAM, node file, FSM and tt register stay in the top.

## Test plan
- Program g0=MAJ(x0,x1,x2), num_gates=1, out_sel=8, sweep -> done after 256 cycles; tt={16{8'hE8}}.
- Program g0=MAJ(~const0,x0,x1), out_sel=8, sweep -> tt={32{4'hE}}.
- Program a 5-gate network, single mode:
  - Gates: g0=MAJ(x0,x3,x4), g1=MAJ(x3,x6,g0), g2=MAJ(x1,x2,g0), g3=MAJ(x5,g1,g2), g4=MAJ(x0,g2,g3); out_sel=12.
  - Expected: x=7'h07 -> result=1; x=7'h19 -> 0; x=7'h7F -> 1; x=0 -> 0.
  - Each done arrives exactly 6 cycles after start.
- num_gates=0, out_sel=3 (x2), single x=7'h04 -> done 1 cycle after start, result=1. Forward reference g0=MAJ(g1,x0,x1), x=7'h01 -> result=0.
- Control and robustness:
  - start and prog_we while busy: both ignored, run and program unchanged.
  - num_gates=31: behaves as 16.
  - rst_n pulsed mid-sweep: busy, done and tt go to 0 immediately; the next start runs cleanly.
